// File: rtl/risc_toy_pkg.sv
// risc_toy_pkg: shared types and constants for the RISC_TOY memory arbiter.
// Holds the arbiter FSM state encoding, the memory direction constants and
// the default address/data widths used by the core-side ports.
package risc_toy_pkg;

  // Word-address and data widths used by the core and the unified memory.
  localparam int DEFAULT_AW         = 30;
  localparam int DEFAULT_DW         = 32;

  // Consecutive D grants tolerated while a fetch waits (guarded builds only).
  localparam int DEFAULT_STARVE_MAX = 4;

  // Memory direction encoding shared by D_RW and M_RW.
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Arbiter FSM: idle/arbitrating, or one transaction in flight per side.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/risc_toy_mem_arbiter_starve_ctr.sv
// mem_arb_starve_ctr: counts D grants handed out while a fetch is waiting and
// raises force_i once STARVE_MAX of them have happened back to back, so the
// next arbitration hands the memory to the fetch side. Only instantiated when
// ARB_STARVE_GUARD_EN is defined. STARVE_MAX must be at least 1.
module mem_arb_starve_ctr
  import risc_toy_pkg::*;
#(
  parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
  input  logic CLK,
  input  logic RST,
  input  logic idle,
  input  logic i_req,
  input  logic d_grant,
  input  logic i_grant,
  output logic force_i
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] count;

  // Count D grants that bypass a waiting fetch; any fetch grant or an idle
  // cycle with no fetch pending means the fetch side is not starving.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (i_grant || (idle && !i_req)) begin
      count <= '0;
    end else if (d_grant && i_req && (count != COUNT_MAX)) begin
      count <= count + CW'(1);
    end
  end

  assign force_i = (count == COUNT_MAX);

endmodule

// File: rtl/risc_toy_mem_arbiter.sv
// risc_toy_mem_arbiter: shares one single-ported memory between the RISC_TOY
// fetch (I) and load/store (D) sides. One transaction at a time is issued on
// the registered M_* port; the memory acknowledge and read data are steered
// combinationally back to whichever side owns the transaction.
// D requests win arbitration because they belong to an older instruction.
// Optional feature macro: ARB_STARVE_GUARD_EN -- when defined, a starvation
// counter forces an I grant after STARVE_MAX consecutive D grants made while
// a fetch was waiting. When undefined, D priority is strict.
module risc_toy_mem_arbiter
  import risc_toy_pkg::*;
#(
  parameter int AW = DEFAULT_AW,
  parameter int DW = DEFAULT_DW
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_MAX = DEFAULT_STARVE_MAX
`endif
) (
  input  logic          CLK,
  input  logic          RST,
  // fetch side
  input  logic          I_REQ,
  input  logic [AW-1:0] I_ADDR,
  output logic          I_ACK,
  output logic [DW-1:0] I_RDATA,
  // load/store side
  input  logic          D_REQ,
  input  logic          D_RW,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_ACK,
  output logic [DW-1:0] D_RDATA,
  // unified memory side
  output logic          M_REQ,
  output logic          M_RW,
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_WDATA,
  input  logic [DW-1:0] M_RDATA,
  input  logic          M_ACK
);

  arb_state_e state;
  arb_state_e state_nxt;

  logic is_idle;
  logic force_i;
  logic grant_d;
  logic grant_i;

  assign is_idle = (state == ST_IDLE);

`ifdef ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .CLK     (CLK),
    .RST     (RST),
    .idle    (is_idle),
    .i_req   (I_REQ),
    .d_grant (grant_d),
    .i_grant (grant_i),
    .force_i (force_i)
  );
`else
  assign force_i = 1'b0;
`endif

  // Grants are only made while idle. A forced fetch only overrides D when a
  // fetch is actually pending; otherwise D still gets the memory.
  assign grant_d = is_idle && D_REQ && !(force_i && I_REQ);
  assign grant_i = is_idle && I_REQ && (!D_REQ || force_i);

  // Next-state selection: leave IDLE on a grant, return to IDLE on M_ACK.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_d) begin
          state_nxt = ST_BUSY_D;
        end else if (grant_i) begin
          state_nxt = ST_BUSY_I;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (M_ACK) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Memory request registers: loaded from the winner at grant time, held
  // constant while busy, and the request dropped when the memory acknowledges.
  // Fetches are always reads, and write data is zeroed for every read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      M_REQ   <= 1'b0;
      M_RW    <= RW_READ;
      M_ADDR  <= '0;
      M_WDATA <= '0;
    end else if (grant_d) begin
      M_REQ   <= 1'b1;
      M_RW    <= D_RW;
      M_ADDR  <= D_ADDR;
      M_WDATA <= (D_RW == RW_WRITE) ? D_WDATA : '0;
    end else if (grant_i) begin
      M_REQ   <= 1'b1;
      M_RW    <= RW_READ;
      M_ADDR  <= I_ADDR;
      M_WDATA <= '0;
    end else if (is_idle || M_ACK) begin
      M_REQ   <= 1'b0;
    end
  end

  // Completion steering: the memory acknowledge is only honoured while a
  // transaction is in flight, so a stray M_ACK in IDLE never reaches a side.
  assign I_ACK   = (state == ST_BUSY_I) && M_ACK;
  assign D_ACK   = (state == ST_BUSY_D) && M_ACK;
  assign I_RDATA = I_ACK ? M_RDATA : '0;
  assign D_RDATA = (D_ACK && (M_RW == RW_READ)) ? M_RDATA : '0;

endmodule

// File: tb/tb_risc_toy_mem_arbiter.sv
// tb_risc_toy_mem_arbiter: self-checking bench for risc_toy_mem_arbiter.
// Inputs are driven on the falling edge and outputs sampled shortly after it.
// A small memory model answers M_REQ after a programmable delay; expected
// completions are queued per side when a request is presented and checked by
// a monitor when the matching ACK appears. Directed tasks drive M_ACK by hand
// for the cycle-exact scenarios. Honours ARB_STARVE_GUARD_EN for expectations.
`timescale 1ns/1ps
module tb_risc_toy_mem_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          I_REQ = 1'b0;
  logic [AW-1:0] I_ADDR = '0;
  logic          I_ACK;
  logic [DW-1:0] I_RDATA;
  logic          D_REQ = 1'b0;
  logic          D_RW = 1'b0;
  logic [AW-1:0] D_ADDR = '0;
  logic [DW-1:0] D_WDATA = '0;
  logic          D_ACK;
  logic [DW-1:0] D_RDATA;
  logic          M_REQ;
  logic          M_RW;
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_WDATA;
  logic [DW-1:0] M_RDATA;
  logic          M_ACK;

  always #5 CLK = ~CLK;

  risc_toy_mem_arbiter dut (
    .CLK     (CLK),
    .RST     (RST),
    .I_REQ   (I_REQ),
    .I_ADDR  (I_ADDR),
    .I_ACK   (I_ACK),
    .I_RDATA (I_RDATA),
    .D_REQ   (D_REQ),
    .D_RW    (D_RW),
    .D_ADDR  (D_ADDR),
    .D_WDATA (D_WDATA),
    .D_ACK   (D_ACK),
    .D_RDATA (D_RDATA),
    .M_REQ   (M_REQ),
    .M_RW    (M_RW),
    .M_ADDR  (M_ADDR),
    .M_WDATA (M_WDATA),
    .M_RDATA (M_RDATA),
    .M_ACK   (M_ACK)
  );

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t iQ[$];
  txn_t dQ[$];
  txn_t dList[16];
  txn_t iList[16];
  txn_t monExp;
  byte  ackLog[$];

  bit            sbOn = 1'b0;
  bit            autoMem = 1'b0;
  int            ackDelay = 0;
  int            waitCnt = 0;
  logic          autoAck = 1'b0;
  logic          manualAck = 1'b0;
  logic [DW-1:0] autoRdata = '0;
  logic [DW-1:0] manualRdata = '0;
  logic [DW-1:0] memArr [256];

  assign M_ACK   = autoMem ? autoAck : manualAck;
  assign M_RDATA = autoMem ? autoRdata : manualRdata;

  function automatic logic [DW-1:0] memInit(input logic [AW-1:0] a);
    return {16'hC0DE, (8'h5A ^ a[7:0]), a[7:0]};
  endfunction

  function automatic txn_t mkTxn(input logic rw, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata);
    txn_t t;
    t.rw    = rw;
    t.addr  = addr;
    t.wdata = rw ? wdata : '0;
    t.rdata = rw ? '0 : memInit(addr);
    return t;
  endfunction

  // Memory model: acknowledges ackDelay falling edges after M_REQ is seen,
  // returning stored data on reads and all-ones on writes.
  always @(negedge CLK) begin
    if (autoMem && M_REQ) begin
      if (waitCnt >= ackDelay) begin
        autoAck   = 1'b1;
        autoRdata = M_RW ? 32'hFFFF_FFFF : memArr[M_ADDR[7:0]];
        if (M_RW) memArr[M_ADDR[7:0]] = M_WDATA;
        waitCnt   = 0;
      end else begin
        autoAck   = 1'b0;
        autoRdata = '0;
        waitCnt++;
      end
    end else begin
      autoAck   = 1'b0;
      autoRdata = '0;
      waitCnt   = 0;
    end
  end

  // Scoreboard monitor: every ACK must match the oldest queued transaction.
  always @(negedge CLK) begin
    #2;
    if (sbOn && I_ACK) begin
      assertCount++;
      if (iQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL sb_i_unexpected: I_ACK=1 got, no pending fetch required");
      end else begin
        monExp = iQ.pop_front();
        assertCount++;
        if ({M_ADDR, M_RW, I_RDATA, D_ACK} !== {monExp.addr, 1'b0, monExp.rdata, 1'b0}) begin
          failCount++;
          $display("[TB] FAIL sb_i_data: got addr=%h rw=%b rdata=%h dack=%b, expected addr=%h rw=0 rdata=%h dack=0",
                   M_ADDR, M_RW, I_RDATA, D_ACK, monExp.addr, monExp.rdata);
        end
      end
    end
    if (sbOn && D_ACK) begin
      assertCount++;
      if (dQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL sb_d_unexpected: D_ACK=1 got, no pending data request required");
      end else begin
        monExp = dQ.pop_front();
        assertCount++;
        if ({M_ADDR, M_RW, M_WDATA, D_RDATA} !== {monExp.addr, monExp.rw, monExp.wdata, monExp.rdata}) begin
          failCount++;
          $display("[TB] FAIL sb_d_data: got addr=%h rw=%b wdata=%h rdata=%h, expected addr=%h rw=%b wdata=%h rdata=%h",
                   M_ADDR, M_RW, M_WDATA, D_RDATA, monExp.addr, monExp.rw, monExp.wdata, monExp.rdata);
        end
      end
    end
  end

  task automatic applyStimulus(input logic iReq, input logic [AW-1:0] iAddr,
                               input logic dReq, input logic dRw,
                               input logic [AW-1:0] dAddr, input logic [DW-1:0] dWdata);
    I_REQ   = iReq;
    I_ADDR  = iAddr;
    D_REQ   = dReq;
    D_RW    = dRw;
    D_ADDR  = dAddr;
    D_WDATA = dWdata;
  endtask

  // Drives dList[0..nD-1] and iList[0..nI-1] as back-to-back requesters,
  // presenting the next transaction (or dropping REQ) the cycle after ACK.
  task automatic runTraffic(input int nD, input int nI, input int budget, output bit done);
    int  di = 0;
    int  ii = 0;
    bit  dPend = 1'b0;
    bit  iPend = 1'b0;
    done = 1'b0;
    ackLog.delete();
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK);
      if (!dPend) begin
        if (di < nD) begin
          applyStimulus(I_REQ, I_ADDR, 1'b1, dList[di].rw, dList[di].addr,
                        dList[di].rw ? dList[di].wdata : 32'h0BAD_0BAD);
          dQ.push_back(dList[di]);
          dPend = 1'b1;
        end else begin
          D_REQ = 1'b0;
        end
      end
      if (!iPend) begin
        if (ii < nI) begin
          I_REQ  = 1'b1;
          I_ADDR = iList[ii].addr;
          iQ.push_back(iList[ii]);
          iPend = 1'b1;
        end else begin
          I_REQ = 1'b0;
        end
      end
      #1;
      if (D_ACK) begin
        dPend = 1'b0;
        di++;
        ackLog.push_back("D");
      end
      if (I_ACK) begin
        iPend = 1'b0;
        ii++;
        ackLog.push_back("I");
      end
      if (di >= nD && ii >= nI) begin
        done = 1'b1;
        break;
      end
    end
    @(negedge CLK);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge CLK);
    #1;
    assertCount++;
    if ({M_REQ, M_RW, M_ADDR, M_WDATA, I_ACK, D_ACK, I_RDATA, D_RDATA} !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got mreq=%b mrw=%b maddr=%h mwdata=%h iack=%b dack=%b, expected all 0",
               M_REQ, M_RW, M_ADDR, M_WDATA, I_ACK, D_ACK);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_single_fetch();
    autoMem = 1'b0;
    @(negedge CLK);
    applyStimulus(1'b1, 30'h10, 1'b0, 1'b0, '0, '0);
    #1;
    assertCount++;
    if (M_REQ !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL fetch_c0_mreq: got %b expected 0", M_REQ);
    end
    for (int c = 1; c <= 2; c++) begin
      @(negedge CLK);
      #1;
      assertCount++;
      if ({M_REQ, M_RW, M_ADDR, I_ACK} !== {1'b1, 1'b0, 30'h10, 1'b0}) begin
        failCount++;
        $display("[TB] FAIL fetch_c%0d_busy: got mreq=%b mrw=%b maddr=%h iack=%b expected 1 0 10 0",
                 c, M_REQ, M_RW, M_ADDR, I_ACK);
      end
    end
    @(negedge CLK);
    manualAck   = 1'b1;
    manualRdata = 32'hDEAD_BEEF;
    #1;
    assertCount++;
    if ({M_REQ, I_ACK, I_RDATA, D_ACK, D_RDATA} !== {1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0}) begin
      failCount++;
      $display("[TB] FAIL fetch_c3_ack: got mreq=%b iack=%b irdata=%h dack=%b drdata=%h expected 1 1 deadbeef 0 0",
               M_REQ, I_ACK, I_RDATA, D_ACK, D_RDATA);
    end
    @(negedge CLK);
    manualAck   = 1'b0;
    manualRdata = '0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    #1;
    assertCount++;
    if ({M_REQ, I_ACK, I_RDATA} !== {1'b0, 1'b0, 32'h0}) begin
      failCount++;
      $display("[TB] FAIL fetch_c4_done: got mreq=%b iack=%b irdata=%h expected 0 0 0", M_REQ, I_ACK, I_RDATA);
    end
  endtask

  task automatic test_store();
    autoMem = 1'b0;
    @(negedge CLK);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 30'h20, 32'h1234_5678);
    #1;
    assertCount++;
    if (M_REQ !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL store_c0_mreq: got %b expected 0", M_REQ);
    end
    @(negedge CLK);
    manualAck   = 1'b1;
    manualRdata = 32'hFFFF_FFFF;
    #1;
    assertCount++;
    if ({M_REQ, M_RW, M_ADDR, M_WDATA, D_ACK, D_RDATA, I_ACK} !==
        {1'b1, 1'b1, 30'h20, 32'h1234_5678, 1'b1, 32'h0, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL store_c1_ack: got mreq=%b mrw=%b maddr=%h mwdata=%h dack=%b drdata=%h iack=%b expected 1 1 20 12345678 1 0 0",
               M_REQ, M_RW, M_ADDR, M_WDATA, D_ACK, D_RDATA, I_ACK);
    end
    @(negedge CLK);
    manualAck   = 1'b0;
    manualRdata = '0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    #1;
    assertCount++;
    if ({M_REQ, D_ACK} !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL store_c2_done: got mreq=%b dack=%b expected 0 0", M_REQ, D_ACK);
    end
  endtask

  task automatic test_simultaneous();
    int   dAckCyc = -1;
    int   iReqCyc = -1;
    logic [AW-1:0] iAddrSeen = '0;
    autoMem  = 1'b1;
    ackDelay = 0;
    sbOn     = 1'b1;
    @(negedge CLK);
    applyStimulus(1'b1, 30'h84, 1'b1, 1'b0, 30'h44, 32'h0BAD_0BAD);
    dQ.push_back(mkTxn(1'b0, 30'h44, '0));
    iQ.push_back(mkTxn(1'b0, 30'h84, '0));
    for (int k = 1; k < 20 && iReqCyc < 0; k++) begin
      @(negedge CLK);
      if (dAckCyc >= 0) D_REQ = 1'b0;
      #1;
      if (dAckCyc >= 0 && M_REQ) begin
        iReqCyc   = k;
        iAddrSeen = M_ADDR;
      end
      if (D_ACK && dAckCyc < 0) dAckCyc = k;
    end
    @(negedge CLK);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge CLK);
    assertCount++;
    if (dAckCyc !== 1) begin
      failCount++;
      $display("[TB] FAIL simul_d_first: D_ACK cycle got %0d expected 1", dAckCyc);
    end
    assertCount++;
    if (iReqCyc - dAckCyc !== 2 || iReqCyc < 0) begin
      failCount++;
      $display("[TB] FAIL simul_i_gap: I M_REQ cycle got %0d expected %0d", iReqCyc, dAckCyc + 2);
    end
    assertCount++;
    if (iAddrSeen !== 30'h84) begin
      failCount++;
      $display("[TB] FAIL simul_i_addr: got %h expected 84", iAddrSeen);
    end
    assertCount++;
    if (iQ.size() + dQ.size() !== 0) begin
      failCount++;
      $display("[TB] FAIL simul_drain: got %0d pending expected 0", iQ.size() + dQ.size());
      iQ.delete();
      dQ.delete();
    end
    sbOn = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit done;
    autoMem  = 1'b1;
    ackDelay = 1;
    sbOn     = 1'b1;
    dList[0] = mkTxn(1'b0, 30'h40, '0);
    dList[1] = mkTxn(1'b1, 30'h41, 32'hA1B2_C3D4);
    dList[2] = mkTxn(1'b0, 30'h42, '0);
    for (int n = 0; n < 3; n++) iList[n] = mkTxn(1'b0, AW'(32'h80 + n), '0);
    runTraffic(3, 3, 200, done);
    repeat (2) @(negedge CLK);
    assertCount++;
    if (!done || iQ.size() + dQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL b2b_complete: got done=%0d pending=%0d expected done=1 pending=0",
               done, iQ.size() + dQ.size());
      iQ.delete();
      dQ.delete();
    end
    assertCount++;
    if (memArr[8'h41] !== 32'hA1B2_C3D4) begin
      failCount++;
      $display("[TB] FAIL b2b_store: got %h expected a1b2c3d4", memArr[8'h41]);
    end
    sbOn = 1'b0;
  endtask

  task automatic test_starvation();
    bit  done;
    byte want;
    autoMem  = 1'b1;
    ackDelay = 0;
    sbOn     = 1'b1;
    for (int n = 0; n < 12; n++) dList[n] = mkTxn(1'b0, AW'(32'h50 + n), '0);
    for (int n = 0; n < 3; n++)  iList[n] = mkTxn(1'b0, AW'(32'h90 + n), '0);
    runTraffic(12, 3, 400, done);
    repeat (2) @(negedge CLK);
    assertCount++;
    if (!done || ackLog.size() != 15) begin
      failCount++;
      $display("[TB] FAIL starve_complete: got done=%0d acks=%0d expected done=1 acks=15", done, ackLog.size());
    end
    for (int n = 0; n < 15 && n < ackLog.size(); n++) begin
`ifdef ARB_STARVE_GUARD_EN
      want = (n % 5 == 4) ? "I" : "D";
`else
      want = (n >= 12) ? "I" : "D";
`endif
      assertCount++;
      if (ackLog[n] !== want) begin
        failCount++;
        $display("[TB] FAIL starve_order_%0d: got %c expected %c", n, ackLog[n], want);
      end
    end
    iQ.delete();
    dQ.delete();
    sbOn = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    autoMem = 1'b0;
    @(negedge CLK);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 30'h30, '0);
    @(negedge CLK);
    #1;
    assertCount++;
    if (M_REQ !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL rstmid_c1_mreq: got %b expected 1", M_REQ);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    #1;
    assertCount++;
    if ({M_REQ, M_RW, M_ADDR, M_WDATA, I_ACK, D_ACK, I_RDATA, D_RDATA} !== '0) begin
      failCount++;
      $display("[TB] FAIL rstmid_c3_zero: got mreq=%b maddr=%h dack=%b drdata=%h expected all 0",
               M_REQ, M_ADDR, D_ACK, D_RDATA);
    end
    @(negedge CLK);
    manualAck   = 1'b1;
    manualRdata = 32'h1357_2468;
    #1;
    assertCount++;
    if ({D_ACK, D_RDATA, I_ACK} !== '0) begin
      failCount++;
      $display("[TB] FAIL rstmid_late_ack: got dack=%b drdata=%h iack=%b expected 0 0 0", D_ACK, D_RDATA, I_ACK);
    end
    @(negedge CLK);
    manualAck   = 1'b0;
    manualRdata = '0;
    #1;
    assertCount++;
    if (M_REQ !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rstmid_c5_idle: got mreq=%b expected 0", M_REQ);
    end
  endtask

  task automatic test_spurious_ack();
    autoMem = 1'b0;
    @(negedge CLK);
    manualAck   = 1'b1;
    manualRdata = 32'hCAFE_F00D;
    #1;
    assertCount++;
    if ({I_ACK, D_ACK, I_RDATA, D_RDATA} !== '0) begin
      failCount++;
      $display("[TB] FAIL spurious_ack: got iack=%b dack=%b irdata=%h drdata=%h expected 0 0 0 0",
               I_ACK, D_ACK, I_RDATA, D_RDATA);
    end
    @(negedge CLK);
    manualAck   = 1'b0;
    manualRdata = '0;
    #1;
    assertCount++;
    if (M_REQ !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL spurious_state: got mreq=%b expected 0", M_REQ);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) memArr[a] = memInit(AW'(a));
    $display("[TB] starting risc_toy_mem_arbiter bench");
    test_reset();
    test_single_fetch();
    test_store();
    test_simultaneous();
    test_back_to_back();
    test_starvation();
    test_reset_mid_op();
    test_spurious_ack();
    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
